// File: rtl/multi_threshold_tracker.sv
// multi_threshold_tracker
//   Per-channel hysteretic threshold tracker with a first-crossing arbiter.
//   Each channel moves NEVER -> ABOVE on a sample strictly above thresh_hi_i.
//   It falls ABOVE -> BELOW on a sample strictly below the effective low
//   threshold, which is min(thresh_lo_i, thresh_hi_i). It re-enters ABOVE
//   from BELOW on a sample above thresh_hi_i. A saturating counter tracks
//   the valid samples seen since the channel was last ABOVE.
//
// Optional feature macro: THRESHOLD_PEAK_EN (adds peak_o, per-channel max
// sample while ABOVE).
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   clr_i                      synchronous clear of all tracking state (wins over valid_i)
//   valid_i                    all channels carry a new sample
//   signal_i                   packed samples, channel k at [k*DW +: DW]
//   thresh_hi_i / thresh_lo_i  rising / falling thresholds
//   above_o                    per-channel ABOVE state
//   threshold_reached_o        sticky, set on first rising crossing
//   samples_since_threshold_o  per-channel saturating count, [k*COUNT_BITS +: COUNT_BITS]
//   crossing_o                 one-cycle pulse per rising crossing
//   peak_o                     (THRESHOLD_PEAK_EN only) per-channel peak sample
//   first_valid_o, first_ch_o  sticky first-crossing channel index
module multi_threshold_tracker #(
  parameter int CHANNELS   = 4,
  parameter int DW         = 16,
  parameter int COUNT_BITS = 16,
  parameter int CH_BITS    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clr_i,
  input  logic                           valid_i,
  input  logic [CHANNELS*DW-1:0]         signal_i,
  input  logic [DW-1:0]                  thresh_hi_i,
  input  logic [DW-1:0]                  thresh_lo_i,
  output logic [CHANNELS-1:0]            above_o,
  output logic [CHANNELS-1:0]            threshold_reached_o,
  output logic [CHANNELS*COUNT_BITS-1:0] samples_since_threshold_o,
  output logic [CHANNELS-1:0]            crossing_o,
`ifdef THRESHOLD_PEAK_EN
  output logic [CHANNELS*DW-1:0]         peak_o,
`endif
  output logic                           first_valid_o,
  output logic [CH_BITS-1:0]             first_ch_o
);

  typedef enum logic [1:0] {
    ST_NEVER = 2'd0,
    ST_ABOVE = 2'd1,
    ST_BELOW = 2'd2
  } trk_state_e;

  trk_state_e            state_p1 [CHANNELS];
  trk_state_e            state_nxt[CHANNELS];
  logic [COUNT_BITS-1:0] cnt_p1   [CHANNELS];
  logic [COUNT_BITS-1:0] cnt_nxt  [CHANNELS];
  logic [DW-1:0]         samp     [CHANNELS];
  logic [CHANNELS-1:0]   reached_p1, reached_nxt;
  logic [CHANNELS-1:0]   cross_p1, cross_nxt;
  logic                  first_vld_p1, first_vld_nxt;
  logic [CH_BITS-1:0]    first_ch_p1, first_ch_nxt;
  logic [DW-1:0]         lo_eff;
`ifdef THRESHOLD_PEAK_EN
  logic [DW-1:0]         peak_p1  [CHANNELS];
  logic [DW-1:0]         peak_nxt [CHANNELS];
`endif

  // Counter stops at all-ones instead of wrapping.
  function automatic logic [COUNT_BITS-1:0] sat_inc(input logic [COUNT_BITS-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // An inverted threshold pair collapses to a single threshold at hi.
  function automatic logic [DW-1:0] eff_low(input logic [DW-1:0] hi, input logic [DW-1:0] lo);
    return (lo <= hi) ? lo : hi;
  endfunction

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    assign samp[g] = signal_i[g*DW +: DW];
    assign above_o[g] = (state_p1[g] == ST_ABOVE);
    assign samples_since_threshold_o[g*COUNT_BITS +: COUNT_BITS] = cnt_p1[g];
`ifdef THRESHOLD_PEAK_EN
    assign peak_o[g*DW +: DW] = peak_p1[g];
`endif
  end

  // ---- stage p0: per-channel next state, count and crossing ----
  always_comb begin
    lo_eff        = eff_low(thresh_hi_i, thresh_lo_i);
    reached_nxt   = reached_p1;
    cross_nxt     = '0;
    first_vld_nxt = first_vld_p1;
    first_ch_nxt  = first_ch_p1;
    for (int k = 0; k < CHANNELS; k++) begin
      state_nxt[k] = state_p1[k];
      cnt_nxt[k]   = cnt_p1[k];
`ifdef THRESHOLD_PEAK_EN
      peak_nxt[k]  = peak_p1[k];
`endif
      if (valid_i) begin
        case (state_p1[k])
          ST_NEVER: begin
            cnt_nxt[k] = '0;
            if (samp[k] > thresh_hi_i) begin
              state_nxt[k]   = ST_ABOVE;
              cross_nxt[k]   = 1'b1;
              reached_nxt[k] = 1'b1;
`ifdef THRESHOLD_PEAK_EN
              peak_nxt[k]    = samp[k];
`endif
            end
          end
          ST_ABOVE: begin
            // The sample that drops the channel out of ABOVE is the first one counted.
            if (samp[k] < lo_eff) begin
              state_nxt[k] = ST_BELOW;
              cnt_nxt[k]   = sat_inc('0);
            end else begin
              cnt_nxt[k]   = '0;
`ifdef THRESHOLD_PEAK_EN
              if (samp[k] > peak_p1[k]) peak_nxt[k] = samp[k];
`endif
            end
          end
          ST_BELOW: begin
            if (samp[k] > thresh_hi_i) begin
              state_nxt[k] = ST_ABOVE;
              cnt_nxt[k]   = '0;
              cross_nxt[k] = 1'b1;
`ifdef THRESHOLD_PEAK_EN
              peak_nxt[k]  = samp[k];
`endif
            end else begin
              cnt_nxt[k]   = sat_inc(cnt_p1[k]);
            end
          end
          default: begin
            state_nxt[k] = ST_NEVER;
            cnt_nxt[k]   = '0;
          end
        endcase
      end
    end
    // Scan downwards so the lowest-indexed crossing channel is the one kept.
    if (!first_vld_p1) begin
      for (int k = CHANNELS - 1; k >= 0; k--) begin
        if (cross_nxt[k]) begin
          first_vld_nxt = 1'b1;
          first_ch_nxt  = CH_BITS'(k);
        end
      end
    end
  end

  // ---- stage p1: registered state and outputs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < CHANNELS; k++) begin
        state_p1[k] <= ST_NEVER;
        cnt_p1[k]   <= '0;
`ifdef THRESHOLD_PEAK_EN
        peak_p1[k]  <= '0;
`endif
      end
      reached_p1   <= '0;
      cross_p1     <= '0;
      first_vld_p1 <= 1'b0;
      first_ch_p1  <= '0;
    end else if (clr_i) begin
      for (int k = 0; k < CHANNELS; k++) begin
        state_p1[k] <= ST_NEVER;
        cnt_p1[k]   <= '0;
`ifdef THRESHOLD_PEAK_EN
        peak_p1[k]  <= '0;
`endif
      end
      reached_p1   <= '0;
      cross_p1     <= '0;
      first_vld_p1 <= 1'b0;
      first_ch_p1  <= '0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        state_p1[k] <= state_nxt[k];
        cnt_p1[k]   <= cnt_nxt[k];
`ifdef THRESHOLD_PEAK_EN
        peak_p1[k]  <= peak_nxt[k];
`endif
      end
      reached_p1   <= reached_nxt;
      cross_p1     <= cross_nxt;
      first_vld_p1 <= first_vld_nxt;
      first_ch_p1  <= first_ch_nxt;
    end
  end

  assign threshold_reached_o = reached_p1;
  assign crossing_o          = cross_p1;
  assign first_valid_o       = first_vld_p1;
  assign first_ch_o          = first_ch_p1;

endmodule

// File: tb/tb_multi_threshold_tracker.sv
// Bench for multi_threshold_tracker: directed scenarios plus a randomized
// phase, all checked against a rule-level reference model.
module tb_multi_threshold_tracker;
  localparam int CH = 4;
  localparam int DW = 16;
  localparam int CB = 4;
  localparam int CNT_MAX = (1 << CB) - 1;

  logic                 clk;
  logic                 rst_n;
  logic                 clr_i;
  logic                 valid_i;
  logic [CH*DW-1:0]     signal_i;
  logic [DW-1:0]        thresh_hi_i;
  logic [DW-1:0]        thresh_lo_i;
  logic [CH-1:0]        above_o;
  logic [CH-1:0]        threshold_reached_o;
  logic [CH*CB-1:0]     samples_since_threshold_o;
  logic [CH-1:0]        crossing_o;
`ifdef THRESHOLD_PEAK_EN
  logic [CH*DW-1:0]     peak_o;
`endif
  logic                 first_valid_o;
  logic [1:0]           first_ch_o;

  multi_threshold_tracker #(.CHANNELS(CH), .DW(DW), .COUNT_BITS(CB)) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .clr_i                     (clr_i),
    .valid_i                   (valid_i),
    .signal_i                  (signal_i),
    .thresh_hi_i               (thresh_hi_i),
    .thresh_lo_i               (thresh_lo_i),
    .above_o                   (above_o),
    .threshold_reached_o       (threshold_reached_o),
    .samples_since_threshold_o (samples_since_threshold_o),
    .crossing_o                (crossing_o),
`ifdef THRESHOLD_PEAK_EN
    .peak_o                    (peak_o),
`endif
    .first_valid_o             (first_valid_o),
    .first_ch_o                (first_ch_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: "seen" = has ever been above hi, "up" = currently above,
  // "since" = unbounded count of valid samples since last above.
  bit m_seen [CH];
  bit m_up   [CH];
  int m_since[CH];
  bit m_reached[CH];
  bit m_cross[CH];
  int m_peak [CH];
  bit m_fv;
  int m_fch;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < CH; k++) begin
      m_seen[k] = 0; m_up[k] = 0; m_since[k] = 0;
      m_reached[k] = 0; m_cross[k] = 0; m_peak[k] = 0;
    end
    m_fv = 0; m_fch = 0;
  endtask

  task automatic model_step(input bit v, input bit c, input logic [CH*DW-1:0] sig,
                            input int hi, input int lo);
    int lo_e;
    int s;
    for (int k = 0; k < CH; k++) m_cross[k] = 0;
    if (c) begin
      model_reset();
      return;
    end
    if (!v) return;
    lo_e = (lo <= hi) ? lo : hi;
    for (int k = 0; k < CH; k++) begin
      s = int'(sig[k*DW +: DW]);
      if (s > hi && (!m_seen[k] || !m_up[k])) begin
        m_seen[k] = 1; m_up[k] = 1; m_since[k] = 0;
        m_cross[k] = 1; m_reached[k] = 1; m_peak[k] = s;
      end else if (m_up[k]) begin
        if (s < lo_e) begin
          m_up[k] = 0; m_since[k] = 1;
        end else if (s > m_peak[k]) begin
          m_peak[k] = s;
        end
      end else if (m_seen[k]) begin
        m_since[k]++;
      end
    end
    if (!m_fv) begin
      for (int k = 0; k < CH; k++) begin
        if (m_cross[k] && !m_fv) begin
          m_fv = 1; m_fch = k;
        end
      end
    end
  endtask

  task automatic compare_all(input string tag);
    logic [CH-1:0]    e_up, e_re, e_cr;
    logic [CH*CB-1:0] e_cnt;
    logic [CH*DW-1:0] e_pk;
    for (int k = 0; k < CH; k++) begin
      e_up[k] = m_up[k];
      e_re[k] = m_reached[k];
      e_cr[k] = m_cross[k];
      e_cnt[k*CB +: CB] = CB'((m_since[k] > CNT_MAX) ? CNT_MAX : m_since[k]);
      e_pk[k*DW +: DW]  = DW'(m_peak[k]);
    end
    check({tag, ".above"},   64'(above_o), 64'(e_up));
    check({tag, ".reached"}, 64'(threshold_reached_o), 64'(e_re));
    check({tag, ".count"},   64'(samples_since_threshold_o), 64'(e_cnt));
    check({tag, ".cross"},   64'(crossing_o), 64'(e_cr));
    check({tag, ".fvalid"},  64'(first_valid_o), 64'(m_fv));
    check({tag, ".fch"},     64'(first_ch_o), 64'(m_fch));
`ifdef THRESHOLD_PEAK_EN
    check({tag, ".peak"},    64'(peak_o), 64'(e_pk));
`endif
  endtask

  function automatic logic [CH*DW-1:0] pack4(input int a, input int b, input int c, input int d);
    return {DW'(d), DW'(c), DW'(b), DW'(a)};
  endfunction

  // One clock: inputs applied, edge taken, outputs checked 1 time unit later.
  task automatic step(input string tag, input bit v, input bit c, input logic [CH*DW-1:0] sig);
    valid_i = v; clr_i = c; signal_i = sig;
    @(posedge clk); #1;
    model_step(v, c, sig, int'(thresh_hi_i), int'(thresh_lo_i));
    compare_all(tag);
  endtask

  int ha[6] = '{0, 1, 1, 0, 0, 0};
  int hc[6] = '{0, 0, 0, 1, 2, 3};
  int hs[6] = '{500, 1200, 900, 700, 700, 900};
  int n_cross;

  initial begin
    rst_n = 1'b0; clr_i = 1'b0; valid_i = 1'b0; signal_i = '0;
    thresh_hi_i = 16'd1000; thresh_lo_i = 16'd800;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_all("reset");
    rst_n = 1'b1;
    step("rel", 1'b0, 1'b0, pack4(1200, 1200, 1200, 1200));

    // Hysteresis on ch0
    n_cross = 0;
    for (int i = 0; i < 6; i++) begin
      step("hyst", 1'b1, 1'b0, pack4(hs[i], 0, 0, 0));
      check("hyst_above0", 64'(above_o[0]), 64'(ha[i]));
      check("hyst_cnt0", 64'(samples_since_threshold_o[CB-1:0]), 64'(hc[i]));
      n_cross += int'(crossing_o[0]);
    end
    check("hyst_npulse", 64'(n_cross), 64'd1);

    // Saturation on ch1
    step("clr", 1'b0, 1'b1, '0);
    step("sat", 1'b1, 1'b0, pack4(0, 1200, 0, 0));
    for (int i = 0; i < 20; i++) step("sat", 1'b1, 1'b0, pack4(0, 100, 0, 0));
    check("sat_hold15", 64'(samples_since_threshold_o[2*CB-1:CB]), 64'd15);
    step("sat_rx", 1'b1, 1'b0, pack4(0, 1200, 0, 0));
    check("sat_cnt0", 64'(samples_since_threshold_o[2*CB-1:CB]), 64'd0);
    check("sat_cross1", 64'(crossing_o[1]), 64'd1);

    // Simultaneous first crossing
    step("clr", 1'b0, 1'b1, '0);
    step("simul", 1'b1, 1'b0, pack4(0, 0, 1200, 1300));
    check("simul_fch", 64'(first_ch_o), 64'd2);
    check("simul_fv", 64'(first_valid_o), 64'd1);
    step("simul2", 1'b1, 1'b0, pack4(1200, 0, 0, 0));
    check("simul_hold", 64'(first_ch_o), 64'd2);

    // Clear coincident with a valid crossing sample
    step("clrv", 1'b1, 1'b1, pack4(1200, 0, 0, 0));
    check("clrv_reached", 64'(threshold_reached_o), 64'd0);
    check("clrv_above", 64'(above_o), 64'd0);
    check("clrv_fv", 64'(first_valid_o), 64'd0);

    // Inverted thresholds
    thresh_lo_i = 16'd1500;
    step("inv", 1'b1, 1'b0, pack4(1100, 0, 0, 0));
    check("inv_up", 64'(above_o[0]), 64'd1);
    step("inv", 1'b1, 1'b0, pack4(999, 0, 0, 0));
    check("inv_down", 64'(above_o[0]), 64'd0);
    thresh_lo_i = 16'd800;

    // Idle gaps between samples
    step("clr", 1'b0, 1'b1, '0);
    for (int i = 0; i < 6; i++) begin
      step("gap", 1'b1, 1'b0, pack4(hs[i], 1200 + 100 * i, 0, 0));
      for (int j = 0; j < 3; j++)
        step("gap_idle", 1'b0, 1'b0, pack4($urandom_range(0, 2000), 1300, 2000, 2000));
    end
`ifdef THRESHOLD_PEAK_EN
    step("clr", 1'b0, 1'b1, '0);
    step("pk", 1'b1, 1'b0, pack4(1200, 0, 0, 0));
    step("pk", 1'b1, 1'b0, pack4(1500, 0, 0, 0));
    step("pk", 1'b1, 1'b0, pack4(1300, 0, 0, 0));
    check("peak0", 64'(peak_o[DW-1:0]), 64'd1500);
`endif

    // Randomized phase
    for (int i = 0; i < 2000; i++) begin
      if (i % 60 == 0) begin
        thresh_hi_i = 16'($urandom_range(600, 1400));
        thresh_lo_i = 16'($urandom_range(300, 1600));
      end
      if (i == 1000) begin
        // Asynchronous reset mid-cycle, then release with valid low.
        valid_i = 1'b1; signal_i = pack4(2000, 2000, 2000, 2000);
        rst_n = 1'b0; #1;
        model_reset();
        compare_all("areset");
        @(negedge clk);
        valid_i = 1'b0; rst_n = 1'b1;
        step("arel", 1'b0, 1'b0, pack4(2000, 2000, 2000, 2000));
      end
      step("rnd", ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) == 0),
           pack4($urandom_range(0, 2000), $urandom_range(0, 2000),
                 $urandom_range(0, 2000), $urandom_range(0, 2000)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/multi_threshold_tracker.md
# multi_threshold_tracker

Multi-channel, hysteretic threshold tracker for the receiver signal-strength path. Each channel independently detects when its magnitude input crosses a runtime-programmable high threshold, then falls back below a low threshold, and counts valid samples since the signal was last above threshold. A cross-channel arbiter reports which channel crossed first since the last clear. The block sits after the per-channel envelope/magnitude stage and feeds the direction-finding and acquisition control logic.

## Interface
- `CHANNELS`, 4: number of independent input channels (1..16).
- `DW`, 16: unsigned sample width.
- `COUNT_BITS`, 16: per-channel counter width.
- `CH_BITS`, `$clog2(CHANNELS)` (min 1): width of the channel index.

- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `clr_i`  in  1  synchronous clear of all tracking state.
- `valid_i`  in  1  all channels carry a new sample this cycle.
- `signal_i`  in  CHANNELS*DW  packed samples; channel k is bits [k*DW +: DW].
- `thresh_hi_i`  in  DW  rising threshold; a sample crosses it when strictly greater.
- `thresh_lo_i`  in  DW  falling threshold; a channel is below it when the sample is strictly less.
- `above_o`  out  CHANNELS  per-channel hysteresis state; 1 while the channel is ABOVE.
- `threshold_reached_o`  out  CHANNELS  sticky; set on the first rising crossing.
- `samples_since_threshold_o`  out  CHANNELS*COUNT_BITS  per-channel count of valid samples since the channel was last ABOVE; saturating.
- `crossing_o`  out  CHANNELS  one-cycle pulse per channel on each rising crossing.
- `first_valid_o`  out  1  sticky; a first channel has been latched.
- `first_ch_o`  out  CH_BITS  index of the first channel to cross.

## Operation
- Per-channel state machine with three states: NEVER, ABOVE, BELOW. Reset and clear put every channel in NEVER.
- Samples are compared only on cycles with `valid_i`=1. On any other cycle all state holds and `crossing_o` is 0.
- Effective low threshold: `thresh_lo_i` if it is ≤ `thresh_hi_i`, otherwise `thresh_hi_i`.
- NEVER → ABOVE when sample > hi.
  - On this transition: `crossing_o[k]` pulses, `threshold_reached_o[k]` is set, and the count is set to 0.
  - While in NEVER, the count stays 0.
- ABOVE: the count is held at 0 on every valid sample. ABOVE → BELOW when sample < effective low.
- BELOW: the count increments on every valid sample.
  - If sample > hi: go to ABOVE, count ← 0, `crossing_o[k]` pulses.
  - A sample that is not above hi and not below effective low leaves the channel in BELOW.
- Saturation: the count stops at 2^COUNT_BITS−1 and never wraps.
- First-channel arbiter:
  - While `first_valid_o`=0, the lowest-indexed channel pulsing `crossing_o` in a cycle is latched into `first_ch_o`, and `first_valid_o` is set.
  - Once `first_valid_o`=1, both outputs hold until reset or clear.
- Thresholds are used combinationally on the valid cycle. A threshold change takes effect on the next valid sample; no re-evaluation is triggered without `valid_i`.

## Timing
- All outputs are registered. A sample presented with `valid_i` at edge N is reflected in every output after edge N (1-cycle latency).
- Because the arbiter registers the same edge, `first_ch_o` and `first_valid_o` update together with `crossing_o`.
- Reset values: `above_o`=0, `threshold_reached_o`=0, `samples_since_threshold_o`=0, `crossing_o`=0, `first_valid_o`=0, `first_ch_o`=0. Peak outputs (see Configuration) also reset to 0.
- `clr_i` has priority over `valid_i` in the same cycle: state is cleared and that sample is discarded.
- Asserting `rst_n` low mid-operation clears all outputs immediately (asynchronously). No sample is consumed on the cycle `rst_n` releases if `valid_i` is 0.

## Configuration
- `THRESHOLD_PEAK_EN` defined:
  - Adds output `peak_o` (CHANNELS*DW).
  - While a channel is ABOVE, its `peak_o` tracks the maximum sample seen.
  - On a NEVER→ABOVE or BELOW→ABOVE transition, `peak_o` loads the crossing sample.
  - The value is held in BELOW, and cleared by reset or `clr_i`.
- `THRESHOLD_PEAK_EN` undefined: no `peak_o` port and no peak registers.

## Test plan
- Reset and hysteresis, CHANNELS=4, DW=16, hi=1000, lo=800, ch0 sequence 500,1200,900,700,700,900 (valid every cycle).
  - Required: `above_o[0]` = 0,1,1,0,0,0.
  - Required: count = 0,0,0,1,2,3.
  - Required: `crossing_o[0]` pulses once, after the 1200 sample.
- Saturation, COUNT_BITS=4: ch1 crosses, then stays below lo for 20 valid samples.
  - Required: count reaches 15 and holds at 15.
  - Required: a sample of 1200 then resets the count to 0 and pulses `crossing_o[1]`.
- Simultaneous first crossing: ch2 and ch3 both exceed hi on the same valid cycle.
  - Required: `first_ch_o`=2 and `first_valid_o`=1.
  - Required: a later ch0 crossing leaves `first_ch_o` at 2.
- `clr_i` coincident with `valid_i` and a sample of 1200 on ch0.
  - Required: all outputs are 0 the next cycle.
  - Required: `threshold_reached_o` stays 0.
- Inverted thresholds, hi=1000, lo=1500: ch0 sequence 1100, 999.
  - Required: ch0 goes ABOVE, then BELOW; the effective low is 1000.
- `valid_i`=0 gaps: insert 3 idle cycles between samples.
  - Required: counts and state are unchanged during the gaps.
  - With `THRESHOLD_PEAK_EN`, ch0 sequence 1200,1500,1300 gives `peak_o[0]`=1500.
